// File: rtl/uart_frame_rx_if.sv
// Receive-side bundle of the UART frame receiver: serial line in, byte/frame strobes out.
// The master modport is the receiver itself; the slave modport is whoever drives the line and consumes frames.
interface uart_frame_rx_if #(
  parameter int W = 40
);
  logic         uart_rx;
  logic [7:0]   byte_data;
  logic         byte_valid;
  logic [W-1:0] frame_data;
  logic         frame_valid;
  logic         frame_err;
  logic         busy;

  modport master (
    input  uart_rx,
    output byte_data, byte_valid, frame_data, frame_valid, frame_err, busy
  );

  modport slave (
    output uart_rx,
    input  byte_data, byte_valid, frame_data, frame_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that packs NUM_BYTES bytes (first byte most significant) into one frame word.
//   state   | meaning
//   S_IDLE  | line idle, waiting for a falling edge; runs the inter-byte timeout
//   S_START | timing to the middle of the start bit to reject glitches
//   S_DATA  | sampling 8 data bits, LSB first, one per bit time
//   S_STOP  | sampling the stop bit; accept the byte or flag a framing error
module uart_frame_rx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int NUM_BYTES    = 5,
  parameter int TIMEOUT_BITS = 16
) (
  input logic            sys_clk,
  input logic            rst_n,
  uart_frame_rx_if.master bus
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int W       = 8 * NUM_BYTES;
  localparam int CNT_W   = $clog2(BIT_CYC);
  localparam int TO_CYC  = TIMEOUT_BITS * BIT_CYC;
  localparam int IDLE_W  = $clog2(TO_CYC + 1);
  localparam int BC_W    = $clog2(NUM_BYTES + 1);

  localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(BIT_CYC - 1);
  localparam logic [IDLE_W-1:0] TO_M1     = IDLE_W'(TO_CYC - 1);
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t state, state_nxt;

  logic rx_meta, rx_s, rx_prev;
  logic fall;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [BC_W-1:0]   byte_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [W-9:0]      frame_buf;
  logic [W-1:0]      frame_nxt;

  logic [7:0]   byte_data_q;
  logic         byte_valid_q;
  logic [W-1:0] frame_data_q;
  logic         frame_valid_q;
  logic         frame_err_q;

  logic cnt_half, cnt_full;
  logic cnt_clr, start_ok, bit_smp, stop_ok, stop_bad;
  logic idle_run, to_hit;

  // Synchroniser resets to the idle (high) level so reset release never looks like a start edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall     = rx_prev & ~rx_s;
  assign cnt_half = (cnt == HALF_M1);
  assign cnt_full = (cnt == FULL_M1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fall) state_nxt = S_START;
      S_START: if (cnt_half) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (cnt_full && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (cnt_full) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    start_ok = 1'b0;
    bit_smp  = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      S_IDLE:  cnt_clr = 1'b1;
      S_START: begin
        cnt_clr  = cnt_half;
        start_ok = cnt_half & ~rx_s;
      end
      S_DATA: begin
        cnt_clr = cnt_full;
        bit_smp = cnt_full;
      end
      S_STOP: begin
        cnt_clr  = cnt_full;
        stop_ok  = cnt_full & rx_s;
        stop_bad = cnt_full & ~rx_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // The timeout only guards a partial frame; a new start edge restarts the idle window.
  assign idle_run  = (state == S_IDLE) && (byte_cnt != '0) && !fall;
  assign to_hit    = idle_run && (idle_cnt == TO_M1);
  assign frame_nxt = {frame_buf, shift};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      byte_cnt      <= '0;
      idle_cnt      <= '0;
      frame_buf     <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      cnt           <= cnt_clr ? '0 : cnt + 1'b1;
      byte_valid_q  <= stop_ok;
      frame_valid_q <= stop_ok && (byte_cnt == LAST_BYTE);
      frame_err_q   <= stop_bad || to_hit;

      if (start_ok)     bit_idx <= '0;
      else if (bit_smp) bit_idx <= bit_idx + 1'b1;

      if (bit_smp) shift <= {rx_s, shift[7:1]};

      if (idle_run && !to_hit) idle_cnt <= idle_cnt + 1'b1;
      else                     idle_cnt <= '0;

      if (stop_ok) begin
        byte_data_q <= shift;
        frame_buf   <= frame_nxt[W-9:0];
        if (byte_cnt == LAST_BYTE) begin
          frame_data_q <= frame_nxt;
          byte_cnt     <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (stop_bad || to_hit) begin
        byte_cnt <= '0;
      end
    end
  end

  assign bus.byte_data   = byte_data_q;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = (state != S_IDLE) || (byte_cnt != '0);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: serial bytes in, byte/frame/error strobes logged and compared.
// Runs at 16 clocks per bit so the whole plan fits in a short simulation.
module tb_uart_frame_rx;
  localparam int BC = 16;
  localparam int NB = 5;
  localparam int W  = 8 * NB;
  localparam int TO = 16 * BC;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  uart_frame_rx_if #(.W(W)) bus ();

  uart_frame_rx #(
    .CLK_FREQ(1600000),
    .BAUD(100000),
    .NUM_BYTES(NB),
    .TIMEOUT_BITS(16)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  logic [7:0]   byte_q[$];
  logic [W-1:0] frame_q[$];
  int err_cnt  = 0;
  int fv_alone = 0;
  int cyc      = 0;
  int last_bv_cyc = 0;
  int err_cyc  = 0;

  always @(negedge sys_clk) begin
    cyc++;
    if (bus.byte_valid) begin
      byte_q.push_back(bus.byte_data);
      last_bv_cyc = cyc;
    end
    if (bus.frame_valid) begin
      frame_q.push_back(bus.frame_data);
      if (!bus.byte_valid) fv_alone++;
    end
    if (bus.frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic clear_mon();
    byte_q.delete();
    frame_q.delete();
    err_cnt  = 0;
    fv_alone = 0;
  endtask

  task automatic line(input logic v, input int n);
    bus.uart_rx = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
    line(1'b0, BC);
    for (int i = 0; i < 8; i++) line(b[i], BC);
    line(stop, BC);
    line(1'b1, gap * BC);
  endtask

  task automatic chk_frame(input string tag, input int idx, input logic [W-1:0] exp);
    if (frame_q.size() > idx) chk(tag, 64'(frame_q[idx]), 64'(exp));
    else                      chk({tag, "_missing"}, 64'(frame_q.size()), 64'(idx + 1));
  endtask

  logic [7:0] v1[5] = '{8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] va[5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
  logic [7:0] v4[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  logic [7:0] v5[5] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
  logic [7:0] v6[10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                         8'hC6, 8'hC7, 8'hC8, 8'hC9, 8'hCA};
  logic [7:0] b3;

  initial begin
    bus.uart_rx = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_byte_valid", 64'(bus.byte_valid), 64'd0);
    chk("rst_frame_data", 64'(bus.frame_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    line(1'b1, 2 * BC);

    // 1: basic frame with one-bit gaps
    clear_mon();
    for (int i = 0; i < 5; i++) send_byte(v1[i], 1'b1, 1);
    line(1'b1, 2 * BC);
    chk("t1_nbytes", 64'(byte_q.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (byte_q.size() > i) chk($sformatf("t1_byte%0d", i), 64'(byte_q[i]), 64'(v1[i]));
    chk("t1_nframes", 64'(frame_q.size()), 64'd1);
    chk_frame("t1_frame", 0, 40'h10_08_04_02_01);
    chk("t1_fv_align", 64'(fv_alone), 64'd0);
    chk("t1_err", 64'(err_cnt), 64'd0);
    chk("t1_busy", 64'(bus.busy), 64'd0);

    // 2: short low glitch is rejected at mid start bit
    clear_mon();
    line(1'b0, 4);
    chk("t2_busy_in_start", 64'(bus.busy), 64'd1);
    line(1'b1, 3 * BC);
    chk("t2_nbytes", 64'(byte_q.size()), 64'd0);
    chk("t2_err", 64'(err_cnt), 64'd0);
    chk("t2_busy", 64'(bus.busy), 64'd0);

    // 3: framing error drops the partial frame
    clear_mon();
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b1, 1);
    send_byte(8'h33, 1'b0, 1);
    chk("t3_err", 64'(err_cnt), 64'd1);
    chk("t3_nbytes_pre", 64'(byte_q.size()), 64'd2);
    chk("t3_busy_after_err", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 5; i++) send_byte(va[i], 1'b1, 1);
    line(1'b1, 2 * BC);
    chk("t3_nbytes", 64'(byte_q.size()), 64'd7);
    chk("t3_nframes", 64'(frame_q.size()), 64'd1);
    chk_frame("t3_frame", 0, 40'hA1_A2_A3_A4_A5);

    // 4: inter-byte timeout
    clear_mon();
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'h66, 1'b1, 0);
    line(1'b1, 10 * BC);
    chk("t4_busy_partial", 64'(bus.busy), 64'd1);
    chk("t4_err_early", 64'(err_cnt), 64'd0);
    line(1'b1, 10 * BC);
    chk("t4_err", 64'(err_cnt), 64'd1);
    chk("t4_err_delay", 64'(err_cyc - last_bv_cyc), 64'(TO));
    chk("t4_busy", 64'(bus.busy), 64'd0);
    chk("t4_nframes_pre", 64'(frame_q.size()), 64'd0);
    for (int i = 0; i < 5; i++) send_byte(v4[i], 1'b1, 1);
    line(1'b1, 2 * BC);
    chk("t4_nframes", 64'(frame_q.size()), 64'd1);
    chk_frame("t4_frame", 0, 40'h01_02_03_04_05);

    // 5: reset in the middle of bit 4 of byte 3
    send_byte(8'hDE, 1'b1, 1);
    send_byte(8'hAD, 1'b1, 1);
    b3 = 8'hBE;
    line(1'b0, BC);
    for (int i = 0; i < 4; i++) line(b3[i], BC);
    line(b3[4], BC / 2);
    rst_n = 1'b0;
    #1;
    chk("t5_byte_data", 64'(bus.byte_data), 64'd0);
    chk("t5_frame_data", 64'(bus.frame_data), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_strobes", 64'({bus.byte_valid, bus.frame_valid, bus.frame_err}), 64'd0);
    line(1'b1, 3);
    rst_n = 1'b1;
    line(1'b1, 2 * BC);
    clear_mon();
    for (int i = 0; i < 5; i++) send_byte(v5[i], 1'b1, 1);
    line(1'b1, 2 * BC);
    chk("t5_nframes", 64'(frame_q.size()), 64'd1);
    chk_frame("t5_frame", 0, 40'hDE_AD_BE_EF_00);
    chk("t5_err", 64'(err_cnt), 64'd0);

    // 6: two frames back to back with no idle between bytes
    clear_mon();
    for (int i = 0; i < 10; i++) send_byte(v6[i], 1'b1, 0);
    line(1'b1, 2 * BC);
    chk("t6_nbytes", 64'(byte_q.size()), 64'd10);
    chk("t6_nframes", 64'(frame_q.size()), 64'd2);
    chk_frame("t6_frame0", 0, 40'h31_32_33_34_35);
    chk_frame("t6_frame1", 1, 40'hC6_C7_C8_C9_CA);
    chk("t6_hold", 64'(bus.frame_data), 64'h00C6_C7C8_C9CA);
    chk("t6_fv_align", 64'(fv_alone), 64'd0);
    chk("t6_err", 64'(err_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
